// File: rtl/inversek_sched.sv
// Round-robin sequencer for a single shared inversek core: it accepts one (x, y) job,
// resets and runs the core for CORE_LATENCY cycles, then returns theta1/theta2 tagged with the requester ID.
module inversek_sched #(
  parameter int unsigned BIT_WIDTH    = 32,
  parameter int unsigned CORE_LATENCY = 220
) (
  input  logic                 clock,
  input  logic                 rst,
  input  logic                 req0_valid,
  output logic                 req0_ready,
  input  logic [BIT_WIDTH-1:0] req0_x,
  input  logic [BIT_WIDTH-1:0] req0_y,
  input  logic                 req1_valid,
  output logic                 req1_ready,
  input  logic [BIT_WIDTH-1:0] req1_x,
  input  logic [BIT_WIDTH-1:0] req1_y,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic                 resp_id,
  output logic [BIT_WIDTH-1:0] resp_theta1,
  output logic [BIT_WIDTH-1:0] resp_theta2,
  output logic                 core_rst,
  output logic [BIT_WIDTH-1:0] core_x,
  output logic [BIT_WIDTH-1:0] core_y,
  input  logic [BIT_WIDTH-1:0] core_theta1,
  input  logic [BIT_WIDTH-1:0] core_theta2,
  output logic                 busy
);

  localparam int unsigned CW = $clog2(CORE_LATENCY + 1);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 last_grant_q, last_grant_d;
  logic                 resp_valid_q, resp_valid_d;
  logic                 resp_id_q, resp_id_d;
  logic [BIT_WIDTH-1:0] theta1_q, theta1_d;
  logic [BIT_WIDTH-1:0] theta2_q, theta2_d;
  logic [BIT_WIDTH-1:0] core_x_q, core_x_d;
  logic [BIT_WIDTH-1:0] core_y_q, core_y_d;
  logic                 grant0, grant1;

  // On contention the requester that was not served last wins.
  assign grant0 = req0_valid & (~req1_valid | last_grant_q);
  assign grant1 = req1_valid & (~req0_valid | ~last_grant_q);

  assign req0_ready  = (state_q == IDLE) & grant0 & rst;
  assign req1_ready  = (state_q == IDLE) & grant1 & rst;
  assign core_rst    = (state_q == IDLE) | (state_q == LOAD);
  assign busy        = (state_q != IDLE);
  assign resp_valid  = resp_valid_q;
  assign resp_id     = resp_id_q;
  assign resp_theta1 = theta1_q;
  assign resp_theta2 = theta2_q;
  assign core_x      = core_x_q;
  assign core_y      = core_y_q;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_grant_d = last_grant_q;
    resp_valid_d = resp_valid_q;
    resp_id_d    = resp_id_q;
    theta1_d     = theta1_q;
    theta2_d     = theta2_q;
    core_x_d     = core_x_q;
    core_y_d     = core_y_q;
    unique case (state_q)
      IDLE: begin
        if (req0_valid && req0_ready) begin
          core_x_d     = req0_x;
          core_y_d     = req0_y;
          resp_id_d    = 1'b0;
          last_grant_d = 1'b0;
          state_d      = LOAD;
        end else if (req1_valid && req1_ready) begin
          core_x_d     = req1_x;
          core_y_d     = req1_y;
          resp_id_d    = 1'b1;
          last_grant_d = 1'b1;
          state_d      = LOAD;
        end
      end
      LOAD: begin
        cnt_d   = '0;
        state_d = RUN;
      end
      RUN: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(CORE_LATENCY - 1)) begin
          theta1_d     = core_theta1;
          theta2_d     = core_theta2;
          resp_valid_d = 1'b1;
          state_d      = DONE;
        end
      end
      DONE: begin
        if (resp_ready) begin
          resp_valid_d = 1'b0;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      last_grant_q <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_id_q    <= 1'b0;
      theta1_q     <= '0;
      theta2_q     <= '0;
      core_x_q     <= '0;
      core_y_q     <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
      resp_valid_q <= resp_valid_d;
      resp_id_q    <= resp_id_d;
      theta1_q     <= theta1_d;
      theta2_q     <= theta2_d;
      core_x_q     <= core_x_d;
      core_y_q     <= core_y_d;
    end
  end

endmodule

// File: tb/tb_inversek_sched.sv
// Directed bench for inversek_sched; a stand-in core produces a known function of (x, y)
// only once it has been out of reset for the full compute latency.
module tb_inversek_sched;

  localparam int unsigned W = 32;
  localparam int unsigned L = 220;

  logic         clock = 1'b0;
  logic         rst = 1'b0;
  logic         req0_valid = 1'b0, req1_valid = 1'b0, resp_ready = 1'b0;
  logic [W-1:0] req0_x = '0, req0_y = '0, req1_x = '0, req1_y = '0;
  logic         req0_ready, req1_ready, resp_valid, resp_id, core_rst, busy;
  logic [W-1:0] resp_theta1, resp_theta2, core_x, core_y, core_theta1, core_theta2;

  inversek_sched #(.BIT_WIDTH(W), .CORE_LATENCY(L)) dut (
    .clock(clock), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_x(req0_x), .req0_y(req0_y),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_x(req1_x), .req1_y(req1_y),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_theta1(resp_theta1), .resp_theta2(resp_theta2),
    .core_rst(core_rst), .core_x(core_x), .core_y(core_y),
    .core_theta1(core_theta1), .core_theta2(core_theta2), .busy(busy)
  );

  always #5 clock = ~clock;

  function automatic logic [W-1:0] f1(input logic [W-1:0] x, input logic [W-1:0] y);
    return x ^ {y[15:0], y[31:16]} ^ 32'h1357_9BDF;
  endfunction

  function automatic logic [W-1:0] f2(input logic [W-1:0] x, input logic [W-1:0] y);
    return x + (y << 1) + 32'h0000_0101;
  endfunction

  // Stand-in core: output is garbage until it has run L cycles out of reset.
  int cc = 0;
  always @(posedge clock) cc <= core_rst ? 0 : cc + 1;
  assign core_theta1 = (!core_rst && cc >= int'(L) - 1) ? f1(core_x, core_y) : 32'hDEAD_BEEF;
  assign core_theta2 = (!core_rst && cc >= int'(L) - 1) ? f2(core_x, core_y) : 32'hDEAD_BEEF;

  int vectors = 0;
  int errors  = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    resp_ready = 1'b0;
    step();
    step();
    rst = 1'b1;
  endtask

  typedef struct {
    logic         v0, v1;
    logic [W-1:0] x0, y0, x1, y1;
    logic         exp_id;
  } vec_t;

  task automatic run_job(input vec_t v);
    int n;
    logic hit;
    logic [W-1:0] ex, ey;
    resp_ready = 1'b1;
    req0_valid = v.v0; req0_x = v.x0; req0_y = v.y0;
    req1_valid = v.v1; req1_x = v.x1; req1_y = v.y1;
    #1;
    hit = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if ((req0_valid && req0_ready) || (req1_valid && req1_ready)) begin
        hit = 1'b1;
        break;
      end
      step();
    end
    check("accept_seen", 32'(hit), 32'd1);
    if (!hit) return;
    check("grant_id", 32'(req1_ready), 32'(v.exp_id));
    check("grant_excl", 32'(req0_ready & req1_ready), 32'd0);
    ex = v.exp_id ? v.x1 : v.x0;
    ey = v.exp_id ? v.y1 : v.y0;
    step();
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_x = ~v.x0; req0_y = ~v.y0; req1_x = ~v.x1; req1_y = ~v.y1;
    n = 1;
    while (n <= int'(L) + 10) begin
      if (resp_valid) break;
      step();
      n++;
    end
    check("latency", 32'(n), 32'(L + 2));
    check("core_x_hold", core_x, ex);
    check("core_y_hold", core_y, ey);
    check("resp_id", 32'(resp_id), 32'(v.exp_id));
    check("theta1", resp_theta1, f1(ex, ey));
    check("theta2", resp_theta2, f2(ex, ey));
    check("busy_done", 32'(busy), 32'd1);
    step();
    check("resp_clear", 32'(resp_valid), 32'd0);
    check("busy_idle", 32'(busy), 32'd0);
  endtask

  vec_t tbl[8];

  initial begin
    int n, na, nr, late;
    int acc_cyc[4];
    logic acc_id[4], rid[4];
    logic [W-1:0] rt1[4];
    logic [W-1:0] hx, hy;

    tbl[0] = '{1'b1, 1'b0, 32'h0000_8000, 32'h0000_8000, 32'h0, 32'h0, 1'b0};
    tbl[1] = '{1'b0, 1'b1, 32'h0, 32'h0, 32'h0001_2000, 32'hFFFF_4000, 1'b1};
    tbl[2] = '{1'b1, 1'b1, 32'h0003_0000, 32'h0000_0001, 32'h1111_1111, 32'h2222_2222, 1'b0};
    tbl[3] = '{1'b1, 1'b1, 32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1};
    tbl[4] = '{1'b0, 1'b1, 32'h0, 32'h0, 32'hA5A5_5A5A, 32'h0F0F_F0F0, 1'b1};
    tbl[5] = '{1'b1, 1'b1, 32'hFFFF_8000, 32'h0000_C000, 32'h0000_1234, 32'h0000_5678, 1'b0};
    tbl[6] = '{1'b1, 1'b0, 32'h0000_0000, 32'h0000_0000, 32'h0, 32'h0, 1'b0};
    tbl[7] = '{1'b1, 1'b1, 32'h0000_4000, 32'h0000_2000, 32'h0002_8000, 32'hFFFE_8000, 1'b1};

    // Reset with a valid requester present.
    req0_valid = 1'b1; req0_x = 32'h1234_5678; req0_y = 32'h9ABC_DEF0;
    #3;
    check("rst_req0_ready", 32'(req0_ready), 32'd0);
    check("rst_req1_ready", 32'(req1_ready), 32'd0);
    check("rst_core_rst", 32'(core_rst), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_id", 32'(resp_id), 32'd0);
    check("rst_theta1", resp_theta1, 32'd0);
    check("rst_theta2", resp_theta2, 32'd0);
    check("rst_core_x", core_x, 32'd0);
    check("rst_core_y", core_y, 32'd0);
    step();
    check("rst_held_ready", 32'(req0_ready), 32'd0);
    check("rst_held_busy", 32'(busy), 32'd0);
    do_reset();

    // Contention from reset: grants alternate 0,1,0,1 every L+3 cycles.
    req0_valid = 1'b1; req0_x = 32'h0001_0000; req0_y = 32'h0000_8000;
    req1_valid = 1'b1; req1_x = 32'h0000_4000; req1_y = 32'hFFFF_0000;
    resp_ready = 1'b1;
    #1;
    na = 0; nr = 0;
    for (int cyc = 0; cyc < 1200 && (na < 4 || nr < 4); cyc++) begin
      if (na < 4 && ((req0_valid && req0_ready) || (req1_valid && req1_ready))) begin
        acc_cyc[na] = cyc;
        acc_id[na]  = req1_ready;
        na++;
      end
      if (nr < 4 && resp_valid && resp_ready) begin
        rid[nr] = resp_id;
        rt1[nr] = resp_theta1;
        nr++;
      end
      step();
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    check("cont_accepts", 32'(na), 32'd4);
    check("cont_resps", 32'(nr), 32'd4);
    for (int i = 0; i < na; i++) begin
      check("cont_grant", 32'(acc_id[i]), 32'(i % 2));
      if (i > 0) check("cont_spacing", 32'(acc_cyc[i] - acc_cyc[i-1]), 32'(L + 3));
    end
    for (int i = 0; i < nr; i++) begin
      check("cont_resp_id", 32'(rid[i]), 32'(i % 2));
      check("cont_theta1", rt1[i], (i % 2) ? f1(32'h0000_4000, 32'hFFFF_0000)
                                           : f1(32'h0001_0000, 32'h0000_8000));
    end

    // Table of single jobs; expected ids follow the round-robin history from reset.
    do_reset();
    for (int i = 0; i < 8; i++) run_job(tbl[i]);

    // Backpressure in DONE with both requesters pushing.
    resp_ready = 1'b0;
    req0_valid = 1'b1; req0_x = 32'h0000_6000; req0_y = 32'h0000_3000;
    req1_valid = 1'b0;
    #1;
    n = 0;
    while (n < 300 && !(req0_valid && req0_ready)) begin step(); n++; end
    check("bp_accept", 32'(req0_ready), 32'd1);
    step();
    req1_valid = 1'b1;
    req0_x = 32'hFFFF_FFFF; req0_y = 32'hFFFF_FFFF;
    n = 0;
    while (n < int'(L) + 10 && !resp_valid) begin step(); n++; end
    for (int i = 0; i < 50; i++) begin
      check("bp_valid", 32'(resp_valid), 32'd1);
      check("bp_id", 32'(resp_id), 32'd0);
      check("bp_theta1", resp_theta1, f1(32'h0000_6000, 32'h0000_3000));
      check("bp_theta2", resp_theta2, f2(32'h0000_6000, 32'h0000_3000));
      check("bp_busy", 32'(busy), 32'd1);
      check("bp_ready0", 32'(req0_ready), 32'd0);
      check("bp_ready1", 32'(req1_ready), 32'd0);
      step();
    end
    resp_ready = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0;
    step();
    check("bp_release_busy", 32'(busy), 32'd0);
    check("bp_release_valid", 32'(resp_valid), 32'd0);
    check("bp_release_core_rst", 32'(core_rst), 32'd1);

    // Reset mid-RUN at cnt=100 (last grant was requester 0 before this).
    req0_valid = 1'b1; req0_x = 32'h0000_2222; req0_y = 32'h0000_1111;
    #1;
    n = 0;
    while (n < 300 && !(req0_valid && req0_ready)) begin step(); n++; end
    check("mid_accept", 32'(req0_ready), 32'd1);
    step();
    for (int i = 1; i < 102; i++) step();
    check("mid_running", 32'(core_rst), 32'd0);
    rst = 1'b0;
    #1;
    check("mid_rst_core_rst", 32'(core_rst), 32'd1);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_core_x", core_x, 32'd0);
    check("mid_rst_ready0", 32'(req0_ready), 32'd0);
    step();
    req0_valid = 1'b0;
    rst = 1'b1;
    late = 0;
    for (int i = 0; i < 300; i++) begin
      if (resp_valid) late++;
      step();
    end
    check("mid_no_resp", 32'(late), 32'd0);
    hx = 32'h0000_AAAA; hy = 32'h0000_5555;
    run_job('{1'b1, 1'b1, hx, hy, 32'h0003_3333, 32'h0004_4444, 1'b0});
    run_job('{1'b0, 1'b1, 32'h0, 32'h0, 32'h0005_5555, 32'h0006_6666, 1'b1});

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
